// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_reader
// Brief    : Reads (base, count) words from a 1-cycle-latency BRAM port and
//            streams them out through a 2-entry ready/valid buffer.
//            Define BRAM_READER_STRIDE_EN to add a cmd_stride input.
// Revision : 1.0
// ============================================================================
module bram_stream_reader #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ADDR-1:0] cmd_base,
    input  logic [ADDR:0]   cmd_count,
`ifdef BRAM_READER_STRIDE_EN
    input  logic [ADDR-1:0] cmd_stride,
`endif
    output logic [ADDR-1:0] mem_req_addr,
    output logic            mem_req_writeEn,
    output logic [DATA-1:0] mem_req_writeData,
    input  logic [DATA-1:0] mem_rsp_readData,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR:0] c_ONE_CNT = (ADDR+1)'(1);

    state_t          state_q;
    logic [ADDR-1:0] next_addr_q;
    logic [ADDR-1:0] last_addr_q;
    logic [ADDR-1:0] stride_q;
    logic [ADDR:0]   remaining_q;
    logic            inflight_q;
    logic            done_q;
    logic [DATA-1:0] buf_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      occ_q;

    logic            w_pop;
    logic [1:0]      w_occ_d;
    logic            w_issue;
    logic [ADDR-1:0] w_cmd_stride;

`ifdef BRAM_READER_STRIDE_EN
    assign w_cmd_stride = cmd_stride;
`else
    assign w_cmd_stride = ADDR'(1);
`endif

    // Occupancy after this cycle's capture and pop; it doubles as the issue
    // budget, since a read issued now lands one cycle after the capture below.
    assign w_pop   = (occ_q != 2'd0) && out_ready;
    assign w_occ_d = occ_q + {1'b0, inflight_q} - {1'b0, w_pop};
    assign w_issue = (state_q == S_RUN) && (w_occ_d < 2'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            last_addr_q <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            done_q     <= 1'b0;
            occ_q      <= w_occ_d;
            inflight_q <= w_issue;

            if (inflight_q) begin
                buf_q[wr_ptr_q] <= mem_rsp_readData;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (w_issue) begin
                last_addr_q <= next_addr_q;
                next_addr_q <= next_addr_q + stride_q;
                remaining_q <= remaining_q - c_ONE_CNT;
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        next_addr_q <= cmd_base;
                        stride_q    <= w_cmd_stride;
                        remaining_q <= cmd_count;
                        if (cmd_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue && (remaining_q == c_ONE_CNT)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_occ_d == 2'd0) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready         = (state_q == S_IDLE);
    assign mem_req_addr      = w_issue ? next_addr_q : last_addr_q;
    assign mem_req_writeEn   = 1'b0;
    assign mem_req_writeData = '0;
    assign out_valid         = (occ_q != 2'd0);
    assign out_data          = buf_q[rd_ptr_q];
    assign done              = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_stream_reader
// Brief    : Self-checking bench for bram_stream_reader with a queue model.
// Revision : 1.0
// ============================================================================
module tb_bram_stream_reader;

    localparam int DATA = 72;
    localparam int ADDR = 10;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [ADDR-1:0] cmd_base = '0;
    logic [ADDR:0]   cmd_count = '0;
`ifdef BRAM_READER_STRIDE_EN
    logic [ADDR-1:0] cmd_stride = ADDR'(1);
`endif
    logic [ADDR-1:0] mem_req_addr;
    logic            mem_req_writeEn;
    logic [DATA-1:0] mem_req_writeData;
    logic [DATA-1:0] mem_rsp_readData = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DATA-1:0] out_data;
    logic            done;

    bram_stream_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clock             (clock),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_base          (cmd_base),
        .cmd_count         (cmd_count),
`ifdef BRAM_READER_STRIDE_EN
        .cmd_stride        (cmd_stride),
`endif
        .mem_req_addr      (mem_req_addr),
        .mem_req_writeEn   (mem_req_writeEn),
        .mem_req_writeData (mem_req_writeData),
        .mem_rsp_readData  (mem_rsp_readData),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .done              (done)
    );

    always #5 clock = ~clock;

    // Memory contents are a fixed function of the address.
    function automatic logic [DATA-1:0] word_of(input logic [ADDR-1:0] a);
        return {a[7:0], 54'd0, a};
    endfunction

    always @(posedge clock) mem_rsp_readData <= word_of(mem_req_addr);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DATA-1:0] got, input logic [DATA-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: queue of expected beats, busy flag, pending done.
    logic [DATA-1:0] exp_q[$];
    bit              active   = 1'b0;
    bit              exp_done = 1'b0;
    int              tb_stride = 1;
    int              ready_mode = 0;

    initial begin
        bit              prev_hold = 1'b0;
        logic [DATA-1:0] prev_data = '0;
        bit              done_next;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                active    = 1'b0;
                exp_done  = 1'b0;
                prev_hold = 1'b0;
                continue;
            end
            check("write_en", {71'd0, mem_req_writeEn}, '0);
            check("done", {71'd0, done}, {71'd0, exp_done});
            check("cmd_ready", {71'd0, cmd_ready}, {71'd0, !active});
            if (exp_q.size() == 0) check("no_extra_beat", {71'd0, out_valid}, '0);
            if (prev_hold) begin
                check("hold_valid", {71'd0, out_valid}, 72'd1);
                check("hold_data", out_data, prev_data);
            end
            done_next = 1'b0;
            if (cmd_valid && cmd_ready) begin
                for (int k = 0; k < int'(cmd_count); k++)
                    exp_q.push_back(word_of(ADDR'(int'(cmd_base) + k * tb_stride)));
                if (cmd_count == '0) done_next = 1'b1;
                else active = 1'b1;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("beat", out_data, exp_q.pop_front());
                if (exp_q.size() == 0 && active) begin
                    active    = 1'b0;
                    done_next = 1'b1;
                end
            end
            exp_done  = done_next;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        int ph = 0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_cmd(input int base, input int count, input int stride);
        int n = 0;
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd_base  = ADDR'(base);
        cmd_count = (ADDR+1)'(count);
        tb_stride = stride;
`ifdef BRAM_READER_STRIDE_EN
        cmd_stride = ADDR'(stride);
`endif
        do begin
            @(negedge clock);
            n++;
        end while (!cmd_ready && n < 5000);
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout got cmd_ready=0 expected 1");
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while ((active || exp_done || exp_q.size() != 0) && n < 5000);
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got busy expected idle", name);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_cmd_ready", {71'd0, cmd_ready}, 72'd1);
        check("rst_out_valid", {71'd0, out_valid}, '0);
        check("rst_done", {71'd0, done}, '0);
        check("rst_addr", {62'd0, mem_req_addr}, '0);
        check("rst_out_data", out_data, '0);

        // base=5, count=4, consumer always ready: exact cycle timing
        send_cmd(5, 4, 1);
        @(negedge clock); check("t1_addr_T1", {62'd0, mem_req_addr}, 72'd5);
        @(negedge clock); check("t1_addr_T2", {62'd0, mem_req_addr}, 72'd6);
        @(negedge clock); check("t1_beat_T3", out_data, {8'd5, 54'd0, 10'd5});
        check("t1_valid_T3", {71'd0, out_valid}, 72'd1);
        @(negedge clock); check("t1_beat_T4", out_data, {8'd6, 54'd0, 10'd6});
        @(negedge clock); check("t1_beat_T5", out_data, {8'd7, 54'd0, 10'd7});
        @(negedge clock); check("t1_beat_T6", out_data, {8'd8, 54'd0, 10'd8});
        @(negedge clock); check("t1_done_T7", {71'd0, done}, 72'd1);
        check("t1_ready_T7", {71'd0, cmd_ready}, 72'd1);
        wait_idle("t1");

        // address wrap through 0
        send_cmd(1022, 4, 1);
        @(negedge clock); check("wrap_addr0", {62'd0, mem_req_addr}, 72'd1022);
        @(negedge clock); check("wrap_addr1", {62'd0, mem_req_addr}, 72'd1023);
        @(negedge clock); check("wrap_addr2", {62'd0, mem_req_addr}, 72'd0);
        @(negedge clock); check("wrap_addr3", {62'd0, mem_req_addr}, 72'd1);
        wait_idle("wrap");

        // zero-length command
        send_cmd(500, 0, 1);
        @(negedge clock); check("zero_done", {71'd0, done}, 72'd1);
        check("zero_addr", {62'd0, mem_req_addr}, 72'd1);
        check("zero_valid", {71'd0, out_valid}, '0);
        @(negedge clock); check("zero_done_end", {71'd0, done}, '0);
        wait_idle("zero");

        // stalling consumer
        ready_mode = 1;
        send_cmd(300, 16, 1);
        wait_idle("stall");
        ready_mode = 0;

        // reset after three of eight beats
        send_cmd(100, 8, 1);
        repeat (5) @(negedge clock);
        check("rst_mid_beat3", out_data, {8'd102, 54'd0, 10'd102});
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rst_mid_valid", {71'd0, out_valid}, '0);
        check("rst_mid_done", {71'd0, done}, '0);
        check("rst_mid_ready", {71'd0, cmd_ready}, 72'd1);
        send_cmd(0, 2, 1);
        wait_idle("after_rst");

`ifdef BRAM_READER_STRIDE_EN
        send_cmd(2, 3, 3);
        @(negedge clock); check("stride_addr0", {62'd0, mem_req_addr}, 72'd2);
        @(negedge clock); check("stride_addr1", {62'd0, mem_req_addr}, 72'd5);
        @(negedge clock); check("stride_addr2", {62'd0, mem_req_addr}, 72'd8);
        wait_idle("stride");
`endif

        for (int i = 0; i < 25; i++) begin
            int r;
            int cnt;
            int st;
            ready_mode = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 9));
            cnt = (r == 0) ? 0 : (r == 1) ? 1 : int'($urandom_range(1, 40));
`ifdef BRAM_READER_STRIDE_EN
            st = int'($urandom_range(0, 1023));
`else
            st = 1;
`endif
            send_cmd(int'($urandom_range(0, 1023)), cnt, st);
            if ($urandom_range(0, 1) == 1) wait_idle("rand");
        end
        wait_idle("rand_end");

        // full-depth read with random backpressure
        ready_mode = 2;
        send_cmd(int'($urandom_range(0, 1023)), 1024, 1);
        wait_idle("full");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Requester-side master for one port of the team's dual-port BRAM. The BRAM has 1-cycle registered read latency and no backpressure.
- Accepts a (base, count) read command and issues sequential read requests on the BRAM port.
- Returns the read data as a ready/valid stream with full backpressure support, one beat per cycle when unstalled.
- Sits between the BRAM and downstream stream consumers (accelerator datapaths, DMA-out).

Parameters:
- DATA, 72, BRAM word width in bits.
- ADDR, 10, BRAM address width; memory depth 2**ADDR.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  reader can accept a command.
- cmd_base  in  ADDR  first word address.
- cmd_count  in  ADDR+1  number of words to read, 0..2**ADDR.
- mem_req_addr  out  ADDR  BRAM port address.
- mem_req_writeEn  out  1  BRAM port write enable; constant 0.
- mem_req_writeData  out  DATA  BRAM port write data; constant 0.
- mem_rsp_readData  in  DATA  BRAM read data, valid the cycle after the address was presented.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  DATA  output beat.
- done  out  1  one-cycle pulse: all beats of the current command delivered.

Behaviour:
- Reset (synchronous, active-high, clock and reset only): state=IDLE, cmd_ready=1, out_valid=0, out_data=0, done=0, mem_req_addr=0. Buffer and in-flight tracking cleared.
- Reset mid-command: reset wins. The in-flight response is discarded and buffered beats are dropped.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch base and count and go to RUN.
  - If count==0, stay in IDLE and pulse done on the next cycle (no reads, no beats).
- State RUN:
  - Issue a read when (occ + inflight - pop) < 2. Here occ is the 2-entry output buffer occupancy, inflight is 1 if a read was issued last cycle, and pop = out_valid&out_ready.
  - On issue: mem_req_addr = base + issued (modulo 2**ADDR, wraps through 0); issued increments.
  - When the last read is issued, go to DRAIN.
  - cmd_ready=0.
- State DRAIN: no new reads. When occ==0 and inflight==0 after the final pop, pulse done for 1 cycle and return to IDLE. cmd_ready is 1 in that same cycle.
- Response capture: if inflight, mem_rsp_readData is written into the buffer at the end of that cycle. The buffer cannot overflow, by the issue rule.
- Output:
  - out_valid = (occ>0); out_data = head entry; beats are in address order.
  - out_data and out_valid are held stable while out_valid&!out_ready.
- Latency: command accepted in cycle T, first address in T+1, data captured at end of T+2, first out_valid in T+3.
- Throughput: with out_ready held high, 1 beat/cycle; N words complete with done at T+N+3.
- mem_req_addr holds its last value when no read is issued. Idle reads are harmless to the BRAM.
- Count of 2**ADDR reads every word exactly once.

Optional Feature:
- BRAM_READER_STRIDE_EN defined:
  - Adds input cmd_stride (ADDR bits), latched with the command.
  - Address k = base + k*stride, modulo 2**ADDR.
  - Stride 0 re-reads base count times.
- Not defined: no cmd_stride port; stride fixed at 1.

Test Plan:
- Reset, then base=5, count=4, out_ready=1, mem holds word i = i -> beats 5,6,7,8 on consecutive cycles starting T+3; done pulse at T+7; cmd_ready back high in the same cycle.
- base=1022, count=4, ADDR=10 -> mem_req_addr sequence 1022,1023,0,1; beats in that order.
- count=16 with out_ready toggling 1,0,0,1,... -> all 16 beats exactly once, in order; out_data stable while stalled; buffer never holds more than 2.
- count=0 -> no mem_req_addr change, no out_valid; done pulses 1 cycle after accept.
- Reset asserted after 3 of 8 beats -> next cycle out_valid=0, done=0, cmd_ready=1; a new command base=0, count=2 yields exactly beats 0,1.
- With BRAM_READER_STRIDE_EN, base=2, stride=3, count=3 -> beats from addresses 2,5,8.
